ex_div_ctrl: RTL and testbench

//  Sequencing controller for DIV/DIVU in the EX stage: latches operands, runs a 32-step

---
 rtl/ex_div_ctrl_pkg.sv | 19 +
 rtl/ex_div_ctrl_step.sv | 27 ++
 rtl/ex_div_ctrl.sv | 149 ++++++++++++++
 tb/tb_ex_div_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide controller.
package ex_div_ctrl_pkg;

    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STALL_MEM = 3;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef logic [STALL_W-1:0] stall_bus_t;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_ctrl_step.sv
// One restoring shift-subtract iteration over the packed {remainder, quotient} word.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W:0] i_work,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [2*DATA_W:0] o_work
);

    logic [2*DATA_W:0] w_shift;
    logic [DATA_W+1:0] w_diff;
    logic              w_unused_msb;

    // The partial remainder never exceeds the divisor, so the top bit is always shifted out as zero.
    assign w_unused_msb = i_work[2*DATA_W];

    always_comb begin
        w_shift = {i_work[2*DATA_W-1:0], 1'b0};
        w_diff  = {1'b0, w_shift[2*DATA_W:DATA_W]} - {2'b00, i_divisor};
        if (w_diff[DATA_W+1]) begin
            o_work = w_shift;
        end else begin
            o_work = {w_diff[DATA_W:0], w_shift[DATA_W-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div_ctrl.sv
// DIV/DIVU sequencer: latches magnitudes, runs DATA_W restoring steps, applies sign fix-up,
// and stalls EX until the {remainder, quotient} result is ready.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  inst_div,
    input  logic                  inst_divu,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  annul,
    output logic                  stallreq_for_div,
    output logic                  div_ready,
    output logic [2*DATA_W-1:0]   div_result
);

    div_state_e          r_state;
    div_state_e          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_divisor;
    logic [2*DATA_W:0]   r_work;
    logic [2*DATA_W:0]   w_step;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_ready;
    logic [2*DATA_W-1:0] r_result;

    logic                w_req;
    logic                w_start;
    logic                w_last;
    logic                w_release;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic                w_unused_stall;

    assign w_unused_stall = ^stall;

    assign w_req     = inst_div | inst_divu;
    assign w_start   = w_req & ~annul;
    assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_release = (stall[STALL_MEM] == NO_STOP);

    assign stallreq_for_div = w_req & ~r_ready & ~annul;
    assign div_ready        = r_ready;
    assign div_result       = r_result;

    // Signed wins when both decode lines are set; sign flags stay clear in unsigned mode.
    always_comb begin
        w_neg_a = inst_div & opdata1[DATA_W-1];
        w_neg_b = inst_div & opdata2[DATA_W-1];
        w_abs_a = w_neg_a ? -opdata1 : opdata1;
        w_abs_b = w_neg_b ? -opdata2 : opdata2;
    end

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_step)
    );

    always_comb begin
        w_quo_fix = r_neg_q ? -w_step[DATA_W-1:0]        : w_step[DATA_W-1:0];
        w_rem_fix = r_neg_r ? -w_step[2*DATA_W-1:DATA_W] : w_step[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_FREE: begin
                if (w_start) begin
                    w_next_state = (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: w_next_state = DIV_END;
            DIV_ON: begin
                if (w_last) begin
                    w_next_state = DIV_END;
                end
            end
            DIV_END: begin
                if (w_release) begin
                    w_next_state = DIV_FREE;
                end
            end
            default: w_next_state = DIV_FREE;
        endcase
        if (annul) begin
            w_next_state = DIV_FREE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_divisor <= '0;
            r_work    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (r_state == DIV_FREE) begin
            if (w_start && (opdata2 != '0)) begin
                r_work    <= {{(DATA_W+1){1'b0}}, w_abs_a};
                r_divisor <= w_abs_b;
                r_neg_q   <= w_neg_a ^ w_neg_b;
                r_neg_r   <= w_neg_a;
                r_cnt     <= '0;
            end
        end else if (r_state == DIV_ON) begin
            r_work <= w_step;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_result <= '0;
        end else if (annul) begin
            r_ready  <= 1'b0;
            r_result <= '0;
        end else if (r_state == DIV_BYZERO) begin
            r_ready  <= 1'b1;
            r_result <= '0;
        end else if ((r_state == DIV_ON) && w_last) begin
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
        end else if ((r_state == DIV_END) && w_release) begin
            r_ready  <= 1'b0;
            r_result <= '0;
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: expected results queued at request, compared at div_ready.
module tb_ex_div_ctrl;
    import ex_div_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               inst_div;
    logic               inst_divu;
    logic [31:0]        opdata1;
    logic [31:0]        opdata2;
    logic               annul;
    logic               stallreq_for_div;
    logic               div_ready;
    logic [63:0]        div_result;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .inst_div         (inst_div),
        .inst_divu        (inst_divu),
        .opdata1          (opdata1),
        .opdata2          (opdata2),
        .annul            (annul),
        .stallreq_for_div (stallreq_for_div),
        .div_ready        (div_ready),
        .div_result       (div_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic drive(input bit sdiv, input bit udiv, input logic [31:0] a, input logic [31:0] b);
        inst_div  = sdiv;
        inst_divu = udiv;
        opdata1   = a;
        opdata2   = b;
    endtask

    // Waits for div_ready; lat = cycles from request, -1 on timeout; sb counts cycles without stall.
    task automatic wait_ready(output int lat, output int sb);
        sb  = 0;
        lat = -1;
        #1;
        if (stallreq_for_div !== 1'b1) sb++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            #1;
            if (div_ready === 1'b1) begin
                lat = k;
                break;
            end
            if (stallreq_for_div !== 1'b1) sb++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({div_ready, div_result, stallreq_for_div} !== 66'd0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b result=%h stall=%b exp all zero",
                     div_ready, div_result, stallreq_for_div);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int k = 0; k < 5; k++) begin
            opdata1 = $urandom;
            opdata2 = $urandom;
            @(posedge clk);
            #2;
            if ({div_ready, div_result, stallreq_for_div} !== 66'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_outputs got %0d nonzero cycles exp 0", bad);
        end
    endtask

    task automatic test_divu_basic();
        int          lat;
        int          sb;
        logic [63:0] exp;
        exp_q.push_back({32'd2, 32'd14});
        drive(1'b0, 1'b1, 32'd100, 32'd7);
        wait_ready(lat, sb);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        checks++;
        if (sb !== 0) begin failures++; $display("FAIL divu_stall_hold got=%0d gaps exp=0", sb); end
        checks++;
        if (stallreq_for_div !== 1'b0) begin
            failures++; $display("FAIL divu_stall_at_ready got=%b exp=0", stallreq_for_div);
        end
        checks++;
        if (div_result !== exp) begin failures++; $display("FAIL divu_result got=%h exp=%h", div_result, exp); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2;
        checks++;
        if ({div_ready, div_result} !== 65'd0) begin
            failures++; $display("FAIL divu_back_to_free got ready=%b result=%h exp 0", div_ready, div_result);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] tb[4] = '{32'd2,        32'hFFFF_FFFE, 32'd2,        32'hFFFF_FFFF};
        logic [63:0] te[4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'hFFFF_FFFD},
                               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000}};
        bit          tu[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          lat;
        int          sb;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(te[i]);
            drive(1'b1, tu[i], ta[i], tb[i]);
            wait_ready(lat, sb);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== 33 || sb !== 0) begin
                failures++; $display("FAIL signed_timing[%0d] got lat=%0d gaps=%0d exp lat=33 gaps=0", i, lat, sb);
            end
            checks++;
            if (div_result !== exp) begin
                failures++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, div_result, exp);
            end
            drive(1'b0, 1'b0, 32'd0, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero();
        int          lat;
        int          sb;
        logic [63:0] exp;
        exp_q.push_back(64'd0);
        drive(1'b1, 1'b0, 32'd12345, 32'd0);
        wait_ready(lat, sb);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 2 || sb !== 0) begin
            failures++; $display("FAIL byzero_timing got lat=%0d gaps=%0d exp lat=2 gaps=0", lat, sb);
        end
        checks++;
        if (div_result !== exp) begin failures++; $display("FAIL byzero_result got=%h exp=%h", div_result, exp); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_annul();
        int          lat;
        int          sb;
        logic [63:0] exp;
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        #1;
        checks++;
        if (stallreq_for_div !== 1'b0) begin
            failures++; $display("FAIL annul_stall_drop got=%b exp=0", stallreq_for_div);
        end
        @(posedge clk);
        #1;
        annul = 1'b0;
        checks++;
        if ({div_ready, div_result} !== 65'd0) begin
            failures++; $display("FAIL annul_outputs got ready=%b result=%h exp 0", div_ready, div_result);
        end
        exp_q.push_back({32'd0, 32'd3});
        drive(1'b0, 1'b1, 32'd9, 32'd3);
        wait_ready(lat, sb);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL annul_restart_latency got=%0d exp=33", lat); end
        checks++;
        if (div_result !== exp) begin failures++; $display("FAIL annul_restart_result got=%h exp=%h", div_result, exp); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_end_hold();
        int          lat;
        int          sb;
        int          bad = 0;
        logic [63:0] exp;
        stall[STALL_MEM] = STOP;
        exp_q.push_back({32'd1, 32'd111});
        drive(1'b0, 1'b1, 32'd1000, 32'd9);
        wait_ready(lat, sb);
        exp = exp_q.pop_front();
        checks++;
        if (lat !== 33 || div_result !== exp) begin
            failures++; $display("FAIL hold_first got lat=%0d result=%h exp lat=33 result=%h", lat, div_result, exp);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            if (div_ready !== 1'b1 || div_result !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); end
        stall[STALL_MEM] = NO_STOP;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2;
        checks++;
        if ({div_ready, div_result} !== 65'd0) begin
            failures++; $display("FAIL hold_release got ready=%b result=%h exp 0", div_ready, div_result);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          sb;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            sgn = i[0];
            a   = $urandom;
            b   = (i == 4) ? 32'd0 : ((i == 2) ? 32'($urandom_range(1, 50)) : $urandom);
            exp_q.push_back(model(sgn, a, b));
            drive(sgn, ~sgn, a, b);
            wait_ready(lat, sb);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== ((b == 32'd0) ? 2 : 33) || sb !== 0) begin
                failures++; $display("FAIL b2b_timing[%0d] got lat=%0d gaps=%0d", i, lat, sb);
            end
            checks++;
            if (div_result !== exp) begin
                failures++; $display("FAIL b2b_result[%0d] a=%h b=%h got=%h exp=%h", i, a, b, div_result, exp);
            end
            drive(1'b0, 1'b0, 32'd0, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        drive(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD);
        for (int k = 0; k < 20; k++) @(posedge clk);
        #4;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checks++;
        if ({div_ready, div_result, stallreq_for_div} !== 66'd0) begin
            failures++; $display("FAIL rst_mid_op got ready=%b result=%h stall=%b exp 0",
                                 div_ready, div_result, stallreq_for_div);
        end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (div_ready !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL rst_no_ready got %0d ready cycles exp 0", pulses); end
    endtask

    task automatic test_reset_in_end();
        int lat;
        int sb;
        stall[STALL_MEM] = STOP;
        drive(1'b0, 1'b1, 32'd100, 32'd7);
        wait_ready(lat, sb);
        checks++;
        if (div_ready !== 1'b1) begin failures++; $display("FAIL rst_end_reach got ready=%b exp=1", div_ready); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({div_ready, div_result} !== 65'd0) begin
            failures++; $display("FAIL rst_in_end got ready=%b result=%h exp 0", div_ready, div_result);
        end
        #1;
        rst = 1'b0;
        stall[STALL_MEM] = NO_STOP;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        stall     = '0;
        annul     = 1'b0;
        inst_div  = 1'b0;
        inst_divu = 1'b0;
        opdata1   = '0;
        opdata2   = '0;
        test_reset();
        test_idle();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_end_hold();
        test_back_to_back();
        test_async_reset();
        test_reset_in_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
